axil_periph_bridge: RTL and testbench

//   AXI4-Lite slave that terminates the single-beat peripheral port of the SoC
//   AXI distributor and drives a simple req/ack register bus into peripherals.

---
 rtl/axil_periph_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_axil_periph_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_periph_bridge.sv
// AXI4-Lite slave to req/ack register bus bridge.
// AW, W and AR are each held in a one-deep buffer. A single FSM issues one
// register access at a time, alternates fairly between reads and writes when
// both are pending, and returns SLVERR on reg_err_i or on a bus timeout.
module axil_periph_bridge #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inport_awvalid_i,
    output logic              inport_awready_o,
    input  logic [31:0]       inport_awaddr_i,
    input  logic              inport_wvalid_i,
    output logic              inport_wready_o,
    input  logic [31:0]       inport_wdata_i,
    input  logic [3:0]        inport_wstrb_i,
    output logic              inport_bvalid_o,
    input  logic              inport_bready_i,
    output logic [1:0]        inport_bresp_o,
    input  logic              inport_arvalid_i,
    output logic              inport_arready_o,
    input  logic [31:0]       inport_araddr_i,
    output logic              inport_rvalid_o,
    input  logic              inport_rready_i,
    output logic [31:0]       inport_rdata_o,
    output logic [1:0]        inport_rresp_o,
    output logic              reg_req_o,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [31:0]       reg_wdata_o,
    output logic [3:0]        reg_strb_o,
    input  logic              reg_ack_i,
    input  logic [31:0]       reg_rdata_i,
    input  logic              reg_err_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUS   = 2'd1;
    localparam logic [1:0] S_WRESP = 2'd2;
    localparam logic [1:0] S_RRESP = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Last BUS cycle before the access is abandoned (unused when TIMEOUT == 0).
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic              aw_held_q;
    logic              w_held_q;
    logic              ar_held_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    logic [1:0]        state_q;
    logic              last_wr_q;
    logic [TMO_W-1:0]  timer_q;

    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;

    logic              bvalid_q;
    logic              rvalid_q;
    logic [1:0]        resp_q;
    logic [31:0]       rdata_q;

    logic              wr_rdy;
    logic              rd_rdy;
    logic              sel_wr;
    logic              sel_rd;
    logic              tmo_hit;

    // Only the low ADDR_W address bits reach the register bus.
    logic              unused_addr;
    assign unused_addr = ^{inport_awaddr_i[31:ADDR_W], inport_araddr_i[31:ADDR_W]};

    // Arbitration: on contention, the op that did not go last wins.
    always_comb begin
        wr_rdy  = aw_held_q & w_held_q;
        rd_rdy  = ar_held_q;
        sel_wr  = (state_q == S_IDLE) & wr_rdy & (~rd_rdy | ~last_wr_q);
        sel_rd  = (state_q == S_IDLE) & rd_rdy & (~wr_rdy | last_wr_q);
        tmo_hit = (TIMEOUT != 0) && (timer_q == TMO_LAST);
    end

    // One-deep AW/W/AR buffers; a flag clears when its op is issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (sel_wr) begin
                aw_held_q <= 1'b0;
            end else if (inport_awvalid_i && !aw_held_q) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= inport_awaddr_i[ADDR_W-1:0];
            end
            if (sel_wr) begin
                w_held_q <= 1'b0;
            end else if (inport_wvalid_i && !w_held_q) begin
                w_held_q <= 1'b1;
                w_data_q <= inport_wdata_i;
                w_strb_q <= inport_wstrb_i;
            end
            if (sel_rd) begin
                ar_held_q <= 1'b0;
            end else if (inport_arvalid_i && !ar_held_q) begin
                ar_held_q <= 1'b1;
                ar_addr_q <= inport_araddr_i[ADDR_W-1:0];
            end
        end
    end

    // Access sequencer: issue, wait for ack or timeout, present response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
            timer_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            resp_q    <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_wr) begin
                        req_q     <= 1'b1;
                        we_q      <= 1'b1;
                        addr_q    <= aw_addr_q;
                        wdata_q   <= w_data_q;
                        strb_q    <= w_strb_q;
                        timer_q   <= '0;
                        last_wr_q <= 1'b1;
                        state_q   <= S_BUS;
                    end else if (sel_rd) begin
                        req_q     <= 1'b1;
                        we_q      <= 1'b0;
                        addr_q    <= ar_addr_q;
                        wdata_q   <= '0;
                        strb_q    <= 4'h0;
                        timer_q   <= '0;
                        last_wr_q <= 1'b0;
                        state_q   <= S_BUS;
                    end
                end
                S_BUS: begin
                    timer_q <= timer_q + 1'b1;
                    // An ack in the final timeout cycle still completes normally.
                    if (reg_ack_i) begin
                        req_q  <= 1'b0;
                        resp_q <= reg_err_i ? RESP_SLVERR : RESP_OKAY;
                        if (we_q) begin
                            bvalid_q <= 1'b1;
                            state_q  <= S_WRESP;
                        end else begin
                            rdata_q  <= reg_rdata_i;
                            rvalid_q <= 1'b1;
                            state_q  <= S_RRESP;
                        end
                    end else if (tmo_hit) begin
                        req_q   <= 1'b0;
                        resp_q  <= RESP_SLVERR;
                        rdata_q <= '0;
                        if (we_q) begin
                            bvalid_q <= 1'b1;
                            state_q  <= S_WRESP;
                        end else begin
                            rvalid_q <= 1'b1;
                            state_q  <= S_RRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (inport_bready_i) begin
                        bvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_RRESP: begin
                    if (inport_rready_i) begin
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output drive; response fields read as zero while not valid.
    always_comb begin
        inport_awready_o = ~aw_held_q;
        inport_wready_o  = ~w_held_q;
        inport_arready_o = ~ar_held_q;
        inport_bvalid_o  = bvalid_q;
        inport_bresp_o   = bvalid_q ? resp_q : 2'b00;
        inport_rvalid_o  = rvalid_q;
        inport_rresp_o   = rvalid_q ? resp_q : 2'b00;
        inport_rdata_o   = rvalid_q ? rdata_q : '0;
        reg_req_o        = req_q;
        reg_we_o         = we_q;
        reg_addr_o       = addr_q;
        reg_wdata_o      = wdata_q;
        reg_strb_o       = strb_q;
    end

endmodule

// File: tb/tb_axil_periph_bridge.sv
// Directed bench for axil_periph_bridge: main instance (default timeout)
// plus a second instance with TIMEOUT=4 for the timeout scenarios.
module tb_axil_periph_bridge;

    logic        clk = 1'b0;
    logic        rst;

    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        req, we;
    logic [15:0] addr;
    logic [31:0] reg_wdata;
    logic [3:0]  strb;
    logic        ack = 1'b0, err = 1'b0;
    logic [31:0] reg_rdata = '0;

    logic        t_awvalid = 1'b0, t_wvalid = 1'b0, t_bready = 1'b0, t_ack = 1'b0;
    logic [31:0] t_awaddr = '0, t_wdata = '0;
    logic [3:0]  t_wstrb = '0;
    logic        t_awready, t_wready, t_arready, t_bvalid, t_rvalid;
    logic [1:0]  t_bresp, t_rresp;
    logic [31:0] t_rdata;
    logic        t_req, t_we;
    logic [15:0] t_addr;
    logic [31:0] t_reg_wdata;
    logic [3:0]  t_strb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_periph_bridge #(.ADDR_W(16), .TIMEOUT(255), .TMO_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .inport_awvalid_i(awvalid), .inport_awready_o(awready), .inport_awaddr_i(awaddr),
        .inport_wvalid_i(wvalid), .inport_wready_o(wready), .inport_wdata_i(wdata),
        .inport_wstrb_i(wstrb),
        .inport_bvalid_o(bvalid), .inport_bready_i(bready), .inport_bresp_o(bresp),
        .inport_arvalid_i(arvalid), .inport_arready_o(arready), .inport_araddr_i(araddr),
        .inport_rvalid_o(rvalid), .inport_rready_i(rready), .inport_rdata_o(rdata),
        .inport_rresp_o(rresp),
        .reg_req_o(req), .reg_we_o(we), .reg_addr_o(addr), .reg_wdata_o(reg_wdata),
        .reg_strb_o(strb), .reg_ack_i(ack), .reg_rdata_i(reg_rdata), .reg_err_i(err)
    );

    axil_periph_bridge #(.ADDR_W(16), .TIMEOUT(4), .TMO_W(3)) dut_tmo (
        .clk_i(clk), .rst_i(rst),
        .inport_awvalid_i(t_awvalid), .inport_awready_o(t_awready), .inport_awaddr_i(t_awaddr),
        .inport_wvalid_i(t_wvalid), .inport_wready_o(t_wready), .inport_wdata_i(t_wdata),
        .inport_wstrb_i(t_wstrb),
        .inport_bvalid_o(t_bvalid), .inport_bready_i(t_bready), .inport_bresp_o(t_bresp),
        .inport_arvalid_i(1'b0), .inport_arready_o(t_arready), .inport_araddr_i(32'h0),
        .inport_rvalid_o(t_rvalid), .inport_rready_i(1'b1), .inport_rdata_o(t_rdata),
        .inport_rresp_o(t_rresp),
        .reg_req_o(t_req), .reg_we_o(t_we), .reg_addr_o(t_addr), .reg_wdata_o(t_reg_wdata),
        .reg_strb_o(t_strb), .reg_ack_i(t_ack), .reg_rdata_i(32'h0), .reg_err_i(1'b0)
    );

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({awready, wready, arready} !== 3'b111) begin errors++;
            $display("FAIL rst_ready got %b exp 111", {awready, wready, arready}); end
        checks++; if ({req, we, bvalid, rvalid} !== 4'b0000) begin errors++;
            $display("FAIL rst_ctl got %b exp 0000", {req, we, bvalid, rvalid}); end
        checks++; if ({addr, reg_wdata, strb, rdata, bresp, rresp} !== '0) begin errors++;
            $display("FAIL rst_data got %h exp 0", {addr, reg_wdata, strb, rdata, bresp, rresp}); end
        rst = 1'b0;
    endtask

    task automatic test_write_same_cycle;
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h9000_0010;
        wvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++; if ({awready, wready, req} !== 3'b000) begin errors++;
            $display("FAIL wr_held got %b exp 000", {awready, wready, req}); end
        @(negedge clk);
        checks++; if ({req, we, addr, reg_wdata, strb} !== {1'b1, 1'b1, 16'h0010, 32'hA5A5_A5A5, 4'hF}) begin errors++;
            $display("FAIL wr_issue got %b %b %h %h %h exp 1 1 0010 a5a5a5a5 f", req, we, addr, reg_wdata, strb); end
        checks++; if ({awready, wready} !== 2'b11) begin errors++;
            $display("FAIL wr_release got %b exp 11", {awready, wready}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (req !== 1'b1 || bvalid !== 1'b0) begin errors++;
                $display("FAIL wr_req_hold cycle %0d got req %b bvalid %b exp 1 0", i, req, bvalid); end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++; if ({req, bvalid, bresp} !== 4'b0100) begin errors++;
            $display("FAIL wr_resp got %b exp 0100", {req, bvalid, bresp}); end
        @(negedge clk);
        checks++; if ({bvalid, bresp} !== 3'b100) begin errors++;
            $display("FAIL wr_resp_hold got %b exp 100", {bvalid, bresp}); end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++; if (bvalid !== 1'b0) begin errors++;
            $display("FAIL wr_b_drop got %b exp 0", bvalid); end
    endtask

    task automatic test_w_before_aw;
        @(negedge clk);
        wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'h3;
        @(negedge clk);
        wvalid = 1'b0;
        checks++; if ({wready, awready, req} !== 3'b010) begin errors++;
            $display("FAIL wfirst_held got %b exp 010", {wready, awready, req}); end
        @(negedge clk);
        checks++; if (req !== 1'b0) begin errors++;
            $display("FAIL wfirst_noreq got %b exp 0", req); end
        awvalid = 1'b1; awaddr = 32'h9000_0020;
        @(negedge clk);
        awvalid = 1'b0;
        checks++; if (req !== 1'b0) begin errors++;
            $display("FAIL wfirst_latency got %b exp 0", req); end
        @(negedge clk);
        checks++; if ({req, we, addr, reg_wdata, strb} !== {1'b1, 1'b1, 16'h0020, 32'h1122_3344, 4'h3}) begin errors++;
            $display("FAIL wfirst_issue got %b %b %h %h %h exp 1 1 0020 11223344 3", req, we, addr, reg_wdata, strb); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        checks++; if ({req, bvalid, bresp} !== 4'b0100) begin errors++;
            $display("FAIL wfirst_resp got %b exp 0100", {req, bvalid, bresp}); end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_read_err;
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h9000_0004;
        @(negedge clk);
        arvalid = 1'b0;
        checks++; if ({arready, req} !== 2'b00) begin errors++;
            $display("FAIL rd_held got %b exp 00", {arready, req}); end
        @(negedge clk);
        checks++; if ({req, we, addr, strb, arready} !== {1'b1, 1'b0, 16'h0004, 4'h0, 1'b1}) begin errors++;
            $display("FAIL rd_issue got %b %b %h %h %b exp 1 0 0004 0 1", req, we, addr, strb, arready); end
        ack = 1'b1; err = 1'b1; reg_rdata = 32'h1234_5678;
        @(negedge clk);
        ack = 1'b0; err = 1'b0; reg_rdata = '0;
        checks++; if ({req, rvalid, rresp, rdata} !== {1'b0, 1'b1, 2'b10, 32'h1234_5678}) begin errors++;
            $display("FAIL rd_resp got %b %b %b %h exp 0 1 10 12345678", req, rvalid, rresp, rdata); end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++; if ({rvalid, rresp, rdata} !== 35'h0) begin errors++;
            $display("FAIL rd_drop got %b %b %h exp 0 00 0", rvalid, rresp, rdata); end
    endtask

    task automatic test_arbitration;
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h9000_0030; wvalid = 1'b1; wdata = 32'h0000_0030; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h9000_0034;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        checks++; if ({req, we, addr, arready} !== {1'b1, 1'b1, 16'h0030, 1'b0}) begin errors++;
            $display("FAIL arb_first got %b %b %h %b exp 1 1 0030 0", req, we, addr, arready); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; bready = 1'b1;
        awvalid = 1'b1; awaddr = 32'h9000_0040; wvalid = 1'b1; wdata = 32'h0000_0040;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        checks++; if ({bvalid, req, awready, wready} !== 4'b0000) begin errors++;
            $display("FAIL arb_queue got %b exp 0000", {bvalid, req, awready, wready}); end
        @(negedge clk);
        checks++; if ({req, we, addr} !== {1'b1, 1'b0, 16'h0034}) begin errors++;
            $display("FAIL arb_second got %b %b %h exp 1 0 0034", req, we, addr); end
        arvalid = 1'b1; araddr = 32'h9000_0038;
        ack = 1'b1; reg_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        ack = 1'b0; reg_rdata = '0; arvalid = 1'b0;
        checks++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin errors++;
            $display("FAIL arb_rdata got %b %b %h exp 1 00 cafef00d", rvalid, rresp, rdata); end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        @(negedge clk);
        checks++; if ({req, we, addr} !== {1'b1, 1'b1, 16'h0040}) begin errors++;
            $display("FAIL arb_third got %b %b %h exp 1 1 0040", req, we, addr); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        @(negedge clk);
        checks++; if ({req, we, addr} !== {1'b1, 1'b0, 16'h0038}) begin errors++;
            $display("FAIL arb_fourth got %b %b %h exp 1 0 0038", req, we, addr); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_rready_stall;
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h9000_0050;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        ack = 1'b1; reg_rdata = 32'h55AA_55AA;
        @(negedge clk);
        ack = 1'b0; reg_rdata = 32'hFFFF_FFFF;
        arvalid = 1'b1; araddr = 32'h9000_0060;
        for (int i = 0; i < 10; i++) begin
            checks++; if ({rvalid, rresp, rdata, req} !== {1'b1, 2'b00, 32'h55AA_55AA, 1'b0}) begin errors++;
                $display("FAIL stall_hold cycle %0d got %b %b %h %b exp 1 00 55aa55aa 0", i, rvalid, rresp, rdata, req); end
            @(negedge clk);
            arvalid = 1'b0;
        end
        checks++; if (arready !== 1'b0) begin errors++;
            $display("FAIL stall_ar_accept got %b exp 0", arready); end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        reg_rdata = '0;
        checks++; if ({rvalid, req} !== 2'b00) begin errors++;
            $display("FAIL stall_drop got %b exp 00", {rvalid, req}); end
        @(negedge clk);
        checks++; if ({req, we, addr} !== {1'b1, 1'b0, 16'h0060}) begin errors++;
            $display("FAIL stall_next got %b %b %h exp 1 0 0060", req, we, addr); end
        ack = 1'b1; reg_rdata = 32'h0000_0001;
        @(negedge clk);
        ack = 1'b0; reg_rdata = '0; rready = 1'b1;
        checks++; if ({rvalid, rdata} !== {1'b1, 32'h1}) begin errors++;
            $display("FAIL stall_next_data got %b %h exp 1 00000001", rvalid, rdata); end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_ack_outside;
        @(negedge clk);
        ack = 1'b1; err = 1'b1; reg_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ack = 1'b0; err = 1'b0; reg_rdata = '0;
        @(negedge clk);
        checks++; if ({req, bvalid, rvalid, rdata} !== 35'h0) begin errors++;
            $display("FAIL stray_ack got %b %b %b %h exp 0 0 0 0", req, bvalid, rvalid, rdata); end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        t_awvalid = 1'b1; t_awaddr = 32'h9000_0008; t_wvalid = 1'b1; t_wdata = 32'h0BAD_0BAD; t_wstrb = 4'hF;
        @(negedge clk);
        t_awvalid = 1'b0; t_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({t_req, t_bvalid} !== 2'b10) begin errors++;
                $display("FAIL tmo_req cycle %0d got %b exp 10", i, {t_req, t_bvalid}); end
        end
        @(negedge clk);
        checks++; if ({t_req, t_bvalid, t_bresp} !== 4'b0110) begin errors++;
            $display("FAIL tmo_resp got %b exp 0110", {t_req, t_bvalid, t_bresp}); end
        t_bready = 1'b1;
        @(negedge clk);
        t_bready = 1'b0;
        checks++; if (t_bvalid !== 1'b0) begin errors++;
            $display("FAIL tmo_drop got %b exp 0", t_bvalid); end
        t_awvalid = 1'b1; t_awaddr = 32'h9000_000C; t_wvalid = 1'b1;
        @(negedge clk);
        t_awvalid = 1'b0; t_wvalid = 1'b0;
        @(negedge clk);
        checks++; if ({t_req, t_addr} !== {1'b1, 16'h000C}) begin errors++;
            $display("FAIL tmo_reissue got %b %h exp 1 000c", t_req, t_addr); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        t_ack = 1'b1;
        @(negedge clk);
        t_ack = 1'b0;
        checks++; if ({t_req, t_bvalid, t_bresp} !== 4'b0100) begin errors++;
            $display("FAIL tmo_ack_wins got %b exp 0100", {t_req, t_bvalid, t_bresp}); end
        t_bready = 1'b1;
        @(negedge clk);
        t_bready = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h9000_0070; wvalid = 1'b1; wdata = 32'h7;
        arvalid = 1'b1; araddr = 32'h9000_0074;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        checks++; if (req !== 1'b1) begin errors++;
            $display("FAIL mid_req got %b exp 1", req); end
        rst = 1'b1;
        #1;
        checks++; if ({req, bvalid, rvalid, awready, wready, arready} !== 6'b000111) begin errors++;
            $display("FAIL mid_reset got %b exp 000111", {req, bvalid, rvalid, awready, wready, arready}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (req !== 1'b0) begin errors++;
            $display("FAIL mid_after got %b exp 0", req); end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_err();
        test_arbitration();
        test_rready_stall();
        test_ack_outside();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
